// File: rtl/cpu6_memresp_pkg.sv
// Shared widths, defaults and helpers for the cpu6 memory responder.
// Build option: define CPU6_WBUF_FWD_EN to enable store-to-load forwarding.
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_MEMRESP_WORDS
`define CPU6_MEMRESP_WORDS 1024
`endif
`ifndef CPU6_WBUF_DEPTH
`define CPU6_WBUF_DEPTH 4
`endif

package cpu6_memresp_pkg;
    localparam int XLEN       = `CPU6_XLEN;
    localparam int BYTE_SHIFT = $clog2(XLEN / 8);

    // Owner of the single RAM write port in a given cycle
    typedef enum logic [1:0] {
        WP_IDLE,
        WP_LOADER,
        WP_DRAIN
    } wport_e;
endpackage

// File: rtl/cpu6_memresp_if.sv
// Core + loader facing bus of the memory responder.
// Build option: CPU6_WBUF_FWD_EN (affects readdata only, not the bus shape).
interface cpu6_memresp_if
    import cpu6_memresp_pkg::*;
#(
    parameter int WBUF_DEPTH = `CPU6_WBUF_DEPTH
);
    localparam int CW = $clog2(WBUF_DEPTH) + 1;

    logic [XLEN-1:0] pc, instr;
    logic            memwriteE;
    logic [XLEN-1:0] dataaddr, writedata, readdata;
    logic            ld_valid, ld_ready;
    logic [XLEN-1:0] ld_addr, ld_data;
    logic [CW-1:0]   wbuf_count;
    logic            wbuf_overflow;

    modport master (
        output pc, memwriteE, dataaddr, writedata, ld_valid, ld_addr, ld_data,
        input  instr, readdata, ld_ready, wbuf_count, wbuf_overflow
    );
    modport slave (
        input  pc, memwriteE, dataaddr, writedata, ld_valid, ld_addr, ld_data,
        output instr, readdata, ld_ready, wbuf_count, wbuf_overflow
    );
endinterface

// File: rtl/cpu6_wbuf.sv
// Posted-store circular FIFO with per-entry index/data/valid.
// Build option: CPU6_WBUF_FWD_EN adds the youngest-match lookup port.
module cpu6_wbuf
    import cpu6_memresp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [IW-1:0]          push_idx,
    input  logic [XLEN-1:0]        push_data,
    input  logic                   pop,
    output logic [IW-1:0]          head_idx,
    output logic [XLEN-1:0]        head_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
`ifdef CPU6_WBUF_FWD_EN
    ,
    input  logic [IW-1:0]          look_idx,
    output logic                   hit,
    output logic [XLEN-1:0]        hit_data
`endif
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [IW-1:0]   idx;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t [DEPTH-1:0] ent;
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (push) ent[wr_ptr] <= '{idx: push_idx, data: push_data};
    end

    // Pop is applied before push so a full-buffer push+pop on the same slot keeps it valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign empty     = !vld[rd_ptr];
    assign full      = (count == (PW + 1)'(DEPTH));
    assign head_idx  = ent[rd_ptr].idx;
    assign head_data = ent[rd_ptr].data;

`ifdef CPU6_WBUF_FWD_EN
    // Walk oldest to youngest so the last match (youngest) wins
    logic [PW-1:0] slot;
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot     = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr + PW'(k);
            if (vld[slot] && ent[slot].idx == look_idx) begin
                hit      = 1'b1;
                hit_data = ent[slot].data;
            end
        end
    end
`endif
endmodule

// File: rtl/cpu6_memresp.sv
// cpu6 memory responder: combinational fetch/load RAM, posted write buffer, loader port.
// Build option: CPU6_WBUF_FWD_EN forwards buffered stores to readdata.
module cpu6_memresp
    import cpu6_memresp_pkg::*;
#(
    parameter int MEM_WORDS  = `CPU6_MEMRESP_WORDS,
    parameter int WBUF_DEPTH = `CPU6_WBUF_DEPTH
) (
    input logic           clk,
    input logic           reset,
    cpu6_memresp_if.slave bus
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(WBUF_DEPTH) + 1;

    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [IW-1:0]   pc_idx, da_idx, ld_idx, head_idx, wr_idx;
    logic [XLEN-1:0] head_data, wr_data;
    logic [CW-1:0]   count;
    logic            empty, full, push, pop, ovf;
    wport_e          wsel;

    function automatic logic [IW-1:0] widx(input logic [XLEN-1:0] a);
        return IW'(a >> BYTE_SHIFT);
    endfunction

    assign pc_idx = widx(bus.pc);
    assign da_idx = widx(bus.dataaddr);
    assign ld_idx = widx(bus.ld_addr);

    // Loader owns the port whenever it asks; nothing writes during reset
    always_comb begin
        wsel    = WP_IDLE;
        wr_idx  = ld_idx;
        wr_data = bus.ld_data;
        if (reset) begin
            if (bus.ld_valid)  wsel = WP_LOADER;
            else if (!empty) begin
                wsel    = WP_DRAIN;
                wr_idx  = head_idx;
                wr_data = head_data;
            end
        end
    end

    assign pop  = (wsel == WP_DRAIN);
    assign push = reset && bus.memwriteE && (!full || pop);

    always_ff @(posedge clk) begin
        if (wsel != WP_IDLE) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset)                                 ovf <= 1'b0;
        else if (bus.memwriteE && full && !pop)     ovf <= 1'b1;
    end

`ifdef CPU6_WBUF_FWD_EN
    logic            hit;
    logic [XLEN-1:0] hit_data;
`endif

    cpu6_wbuf #(.DEPTH(WBUF_DEPTH), .IW(IW)) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_idx  (da_idx),
        .push_data (bus.writedata),
        .pop       (pop),
        .head_idx  (head_idx),
        .head_data (head_data),
        .empty     (empty),
        .full      (full),
        .count     (count)
`ifdef CPU6_WBUF_FWD_EN
        ,
        .look_idx  (da_idx),
        .hit       (hit),
        .hit_data  (hit_data)
`endif
    );

    assign bus.instr = mem[pc_idx];
`ifdef CPU6_WBUF_FWD_EN
    assign bus.readdata = hit ? hit_data : mem[da_idx];
`else
    assign bus.readdata = mem[da_idx];
`endif
    assign bus.ld_ready      = reset;
    assign bus.wbuf_count    = count;
    assign bus.wbuf_overflow = ovf;
endmodule

// File: tb/tb_cpu6_memresp.sv
// Directed bench for cpu6_memresp; expectations track CPU6_WBUF_FWD_EN.
module tb_cpu6_memresp;
    import cpu6_memresp_pkg::*;

`ifdef CPU6_WBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [31:0] STALL_ADDR = 32'h3FC;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cpu6_memresp_if #(.WBUF_DEPTH(4)) bus ();
    cpu6_memresp #(.MEM_WORDS(1024), .WBUF_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ldv;
        logic [31:0] lda, ldd;
        logic        mw;
        logic [31:0] da, wd, pc;
        logic        ci;
        logic [31:0] ei;
        logic        cr;
        logic [31:0] er;
        logic [31:0] ec;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic ldv, logic [31:0] lda, logic [31:0] ldd,
                                logic mw, logic [31:0] da, logic [31:0] wd,
                                logic [31:0] pc, logic ci, logic [31:0] ei,
                                logic cr, logic [31:0] er, logic [31:0] ec);
        vec_t v;
        v.ldv = ldv; v.lda = lda; v.ldd = ldd; v.mw = mw; v.da = da; v.wd = wd;
        v.pc = pc; v.ci = ci; v.ei = ei; v.cr = cr; v.er = er; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ldv, input logic [31:0] lda, input logic [31:0] ldd,
                         input logic mw, input logic [31:0] da, input logic [31:0] wd);
        bus.ld_valid  = ldv;
        bus.ld_addr   = lda;
        bus.ld_data   = ldd;
        bus.memwriteE = mw;
        bus.dataaddr  = da;
        bus.writedata = wd;
    endtask

    initial begin
        reset  = 1'b0;
        bus.pc = '0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick(); tick();
        check("rst_count", 32'(bus.wbuf_count), 0);
        check("rst_ovf", 32'(bus.wbuf_overflow), 0);
        check("rst_ld_ready", 32'(bus.ld_ready), 0);
        reset = 1'b1;
        #1;
        check("ld_ready_out_of_reset", 32'(bus.ld_ready), 1);

        // Dirty the buffer and overflow flag, then reset them away
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, STALL_ADDR, '0, 1'b1, 32'h300 + 32'(4 * i), 32'hEE);
            tick();
        end
        drive(1'b1, STALL_ADDR, '0, 1'b0, '0, '0);
        #1;
        check("garbage_count", 32'(bus.wbuf_count), 4);
        check("garbage_ovf", 32'(bus.wbuf_overflow), 1);
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        check("rerst_count", 32'(bus.wbuf_count), 0);
        check("rerst_ovf", 32'(bus.wbuf_overflow), 0);
        check("rerst_ld_ready", 32'(bus.ld_ready), 0);
        reset = 1'b1;
        tick();

        //         ldv  ld_addr     ld_data  mw   dataaddr  wdata  pc       ci exp_instr cr exp_rd                         cnt
        vt.push_back(mk(1, 32'h0,      32'h13, 0, 32'h0,  32'h0,  32'h0,  0, 0,       0, 0,                              0));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h0,  32'h0,  32'h0,  1, 32'h13,  1, 32'h13,                         0));
        vt.push_back(mk(1, 32'h40,     32'h77, 0, 32'h0,  32'h0,  32'h0,  0, 0,       0, 0,                              0));
        vt.push_back(mk(1, STALL_ADDR, 32'h0,  1, 32'h40, 32'hAA, 32'h40, 1, 32'h77,  1, 32'h77,                         0));
        vt.push_back(mk(1, STALL_ADDR, 32'h0,  0, 32'h40, 32'h0,  32'h40, 1, 32'h77,  1, FWD ? 32'hAA : 32'h77,          1));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h40, 32'h0,  32'h40, 1, 32'h77,  1, FWD ? 32'hAA : 32'h77,          1));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h40, 32'h0,  32'h40, 1, 32'hAA,  1, 32'hAA,                         0));
        vt.push_back(mk(1, STALL_ADDR, 32'h0,  1, 32'h40, 32'h1,  32'h40, 1, 32'hAA,  1, 32'hAA,                         0));
        vt.push_back(mk(1, STALL_ADDR, 32'h0,  1, 32'h40, 32'h2,  32'h40, 1, 32'hAA,  1, FWD ? 32'h1 : 32'hAA,           1));
        vt.push_back(mk(1, STALL_ADDR, 32'h0,  0, 32'h40, 32'h0,  32'h40, 1, 32'hAA,  1, FWD ? 32'h2 : 32'hAA,           2));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h40, 32'h0,  32'h40, 1, 32'hAA,  1, FWD ? 32'h2 : 32'hAA,           2));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h40, 32'h0,  32'h40, 1, 32'h1,   1, FWD ? 32'h2 : 32'h1,            1));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h40, 32'h0,  32'h40, 1, 32'h2,   1, 32'h2,                          0));
        vt.push_back(mk(1, 32'h1043,   32'h99, 0, 32'h0,  32'h0,  32'h0,  0, 0,       0, 0,                              0));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h42, 32'h0,  32'h40, 1, 32'h99,  1, 32'h99,                         0));
        vt.push_back(mk(1, 32'h80,     32'h33, 0, 32'h0,  32'h0,  32'h0,  0, 0,       0, 0,                              0));
        vt.push_back(mk(1, STALL_ADDR, 32'h0,  1, 32'h80, 32'h55, 32'h80, 1, 32'h33,  1, 32'h33,                         0));
        vt.push_back(mk(1, STALL_ADDR, 32'h0,  0, 32'h80, 32'h0,  32'h80, 1, 32'h33,  1, FWD ? 32'h55 : 32'h33,          1));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h80, 32'h0,  32'h80, 1, 32'h33,  1, FWD ? 32'h55 : 32'h33,          1));
        vt.push_back(mk(0, 32'h0,      32'h0,  0, 32'h80, 32'h0,  32'h80, 1, 32'h55,  1, 32'h55,                         0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].ldv, vt[i].lda, vt[i].ldd, vt[i].mw, vt[i].da, vt[i].wd);
            bus.pc = vt[i].pc;
            #1;
            if (vt[i].ci) check($sformatf("v%0d_instr", i), bus.instr, vt[i].ei);
            if (vt[i].cr) check($sformatf("v%0d_readdata", i), bus.readdata, vt[i].er);
            check($sformatf("v%0d_count", i), 32'(bus.wbuf_count), vt[i].ec);
            check($sformatf("v%0d_ovf", i), 32'(bus.wbuf_overflow), 0);
            tick();
        end

        // Overflow: fifth store under loader stall is dropped
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, STALL_ADDR, '0, 1'b1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i));
            #1;
            check($sformatf("fill_count%0d", i), 32'(bus.wbuf_count), 32'(i));
            tick();
        end
        drive(1'b1, STALL_ADDR, '0, 1'b0, '0, '0);
        #1;
        check("ovf_count", 32'(bus.wbuf_count), 4);
        check("ovf_set", 32'(bus.wbuf_overflow), 1);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("drain_count%0d", j), 32'(bus.wbuf_count), 32'(4 - j));
            check($sformatf("drain_ovf%0d", j), 32'(bus.wbuf_overflow), 1);
            tick();
        end
        check("drained_count", 32'(bus.wbuf_count), 0);
        for (int k = 0; k < 4; k++) begin
            bus.pc = 32'h100 + 32'(4 * k);
            #1;
            check($sformatf("drained_ram%0d", k), bus.instr, 32'hB0 + 32'(k));
        end

        // Full boundary with a drain in the same cycle: store accepted
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, STALL_ADDR, '0, 1'b1, 32'h140 + 32'(4 * i), 32'hD0 + 32'(i));
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 32'h150, 32'hD4);
        #1;
        check("full_pre_count", 32'(bus.wbuf_count), 4);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("pushpop_count%0d", j), 32'(bus.wbuf_count), 32'(4 - j));
            tick();
        end
        check("pushpop_empty", 32'(bus.wbuf_count), 0);
        bus.pc = 32'h150;
        #1;
        check("pushpop_ram_last", bus.instr, 32'hD4);
        bus.pc = 32'h14C;
        #1;
        check("pushpop_ram_d3", bus.instr, 32'hD3);

        // Reset in the cycle a drain would happen: entry must not reach RAM
        drive(1'b1, 32'h200, 32'h1111, 1'b0, '0, '0);
        tick();
        drive(1'b1, STALL_ADDR, '0, 1'b1, 32'h200, 32'h2222);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        check("middrain_pre_count", 32'(bus.wbuf_count), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.pc = 32'h200;
        #1;
        check("middrain_count", 32'(bus.wbuf_count), 0);
        check("middrain_ovf_cleared", 32'(bus.wbuf_overflow), 0);
        check("middrain_ram", bus.instr, 32'h1111);
        tick();
        check("middrain_ram_later", bus.instr, 32'h1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
